// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX frame sequencer.
// Frame states, parity codes and the latched per-frame configuration.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MIN_LEN = 5;

  typedef struct packed {
    logic [3:0] len;
    logic [1:0] parity;
    logic       stop2;
  } cfg_t;

  // Data length is forced into MIN_LEN..max_len.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
    if (int'(len) < MIN_LEN) return 4'(MIN_LEN);
    if (int'(len) > max_len) return 4'(max_len);
    return len;
  endfunction

  // Code 2'b11 behaves as no parity.
  function automatic logic par_en(input logic [1:0] p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud tick counter modulo TPB; bit_end marks the tick that closes a bit period.
module uart_bit_timer #(
  parameter int TPB = 1
) (
  input  logic clk,
  input  logic arst,
  input  logic clr,
  input  logic tick,
  output logic bit_end
);

  localparam int CNT_W = (TPB > 1) ? $clog2(TPB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TPB - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = tick & (cnt == LAST);

  always_ff @(posedge clk or posedge arst) begin
    if (arst)       cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (tick)  cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/uart_tx_frame_seq.sv
// UART TX frame sequencer: accepts a word, shifts out start/data/parity/stop bits
// paced by baud_tick, and reports frame position, busy and done.
module uart_tx_frame_seq
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TPB    = 1,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              clr,
  input  logic              baud_tick,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic [3:0]        cfg_len,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              tx_out,
  output logic [IDX_W-1:0]  bit_index,
  output logic              busy,
  output logic              done
);

  state_e             state, state_n;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  data_sh;
  cfg_t               cfg_q;
  logic               tx_n, busy_n, done_n;
  logic [IDX_W-1:0]   idx_n;
  logic               accept, bit_end, last_data;
  logic               par_acc, par_bit;

  assign tx_ready = (state == IDLE) & ~clr;
  assign accept   = tx_valid & tx_ready;

  // Counter is held at zero in IDLE so each frame starts from a fresh tick phase.
  uart_bit_timer #(.TPB(TPB)) u_timer (
    .clk     (clk),
    .arst    (arst),
    .clr     (clr | (state == IDLE)),
    .tick    (baud_tick),
    .bit_end (bit_end)
  );

  // bit_index k is data bit k-1, so the bit to send next is always data_sh[0].
  assign data_sh   = data_q >> bit_index;
  assign last_data = (int'(bit_index) == int'(cfg_q.len));

  always_comb begin
    par_acc = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i < int'(cfg_q.len)) par_acc = par_acc ^ data_q[i];
    par_bit = par_acc ^ (cfg_q.parity == PAR_ODD);
  end

  always_comb begin
    state_n = state;
    tx_n    = tx_out;
    idx_n   = bit_index;
    busy_n  = busy;
    done_n  = 1'b0;
    if (clr) begin
      state_n = IDLE;
      tx_n    = 1'b1;
      idx_n   = '1;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state_n = START;
          tx_n    = 1'b0;
          idx_n   = '0;
          busy_n  = 1'b1;
        end
        START: if (bit_end) begin
          state_n = DATA;
          tx_n    = data_sh[0];
          idx_n   = bit_index + IDX_W'(1);
        end
        DATA: if (bit_end) begin
          idx_n = bit_index + IDX_W'(1);
          if (!last_data) begin
            tx_n = data_sh[0];
          end else if (par_en(cfg_q.parity)) begin
            state_n = PARITY;
            tx_n    = par_bit;
          end else begin
            state_n = STOP1;
            tx_n    = 1'b1;
          end
        end
        PARITY: if (bit_end) begin
          state_n = STOP1;
          tx_n    = 1'b1;
          idx_n   = bit_index + IDX_W'(1);
        end
        STOP1: if (bit_end) begin
          if (cfg_q.stop2) begin
            state_n = STOP2;
            idx_n   = bit_index + IDX_W'(1);
          end else begin
            state_n = IDLE;
            idx_n   = '1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
        STOP2: if (bit_end) begin
          state_n = IDLE;
          idx_n   = '1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
        default: begin
          state_n = IDLE;
          tx_n    = 1'b1;
          idx_n   = '1;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      tx_out    <= 1'b1;
      bit_index <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      tx_out    <= tx_n;
      bit_index <= idx_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Word and config are frozen at accept; later input changes do not reach the frame.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      data_q <= '0;
      cfg_q  <= '0;
    end else if (accept) begin
      data_q <= tx_data;
      cfg_q  <= '{len: clamp_len(cfg_len, DATA_W), parity: cfg_parity, stop2: cfg_stop2};
    end
  end

endmodule
